// File: rtl/tape_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tape_unit
//  Description : Tape store and head controller. Holds TAPE_LEN 3-bit cells
//                and a head pointer, and performs one write/move/fetch step
//                per accepted handshake. Also supports serial preload and
//                reports sticky halt and edge-error status.
//  Revision    : 1.0  initial release
// ============================================================================
module tape_unit #(
    parameter int         TAPE_LEN  = 16,
    parameter int         HEAD_W    = 4,
    parameter logic [2:0] BLANK     = 3'b000,
    parameter int         INIT_HEAD = 8,
    parameter bit         WRAP      = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [2:0]        load_data,
    input  logic              step_valid,
    output logic              step_ready,
    input  logic [2:0]        new_sym,
    input  logic              move_right,
    input  logic              halt_in,
    output logic [2:0]        cur_sym,
    output logic [HEAD_W-1:0] head_pos,
    output logic              halted,
    output logic              edge_err
);

    typedef enum logic [2:0] {
        S_READY = 3'd0,
        S_WRITE = 3'd1,
        S_MOVE  = 3'd2,
        S_FETCH = 3'd3,
        S_HALT  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [HEAD_W-1:0] c_init_head = HEAD_W'(INIT_HEAD);
    localparam logic [HEAD_W-1:0] c_last      = HEAD_W'(TAPE_LEN - 1);
    localparam logic [HEAD_W-1:0] c_first     = '0;
    localparam logic [HEAD_W-1:0] c_one       = HEAD_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_tape [TAPE_LEN];
    logic [HEAD_W-1:0] r_head;
    logic [HEAD_W-1:0] w_head_nxt;
    logic [HEAD_W-1:0] w_head_step;
    logic [2:0]        r_cur;
    logic [2:0]        r_sym;
    logic              r_right;
    logic              r_halted;
    logic              r_edge_err;
    logic              w_accept;
    logic              w_load;
    logic              w_at_edge;
    logic              w_edge_hit;
    logic [2:0]        w_shift_sym;

    // Handshake and load qualification; halt has priority over load, load over step
    assign step_ready  = (r_state == S_READY) & ~load_en & ~halt_in;
    assign w_accept    = step_valid & step_ready;
    assign w_load      = (r_state == S_READY) & load_en & ~halt_in;

    // Head arithmetic wraps naturally because TAPE_LEN is a power of two
    assign w_at_edge   = r_right ? (r_head == c_last) : (r_head == c_first);
    assign w_head_step = r_right ? (r_head + c_one) : (r_head - c_one);

    // Symbol that lands under the head after a one-cell shift
    assign w_shift_sym = (r_head == c_last) ? load_data : r_tape[r_head + c_one];

    assign cur_sym  = r_cur;
    assign head_pos = r_head;
    assign halted   = r_halted;
    assign edge_err = r_edge_err;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_READY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and head-update decode
    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_edge_hit  = 1'b0;
        case (r_state)
            S_READY: begin
                if (halt_in) begin
                    w_state_nxt = S_HALT;
                end else if (load_en) begin
                    w_state_nxt = S_READY;
                end else if (step_valid) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: w_state_nxt = S_MOVE;
            S_MOVE: begin
                if (w_at_edge && !WRAP) begin
                    w_edge_hit  = 1'b1;
                    w_state_nxt = S_ERR;
                end else begin
                    w_head_nxt  = w_head_step;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: w_state_nxt = S_READY;
            S_HALT:  w_state_nxt = S_HALT;
            S_ERR:   w_state_nxt = S_ERR;
            default: w_state_nxt = S_READY;
        endcase
    end

    // Head pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= c_init_head;
        end else begin
            r_head <= w_head_nxt;
        end
    end

    // Tape cells: serial shift on load, single-cell write in WRITE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPE_LEN; i++) begin
                r_tape[i] <= BLANK;
            end
        end else if (w_load) begin
            for (int i = 0; i < TAPE_LEN - 1; i++) begin
                r_tape[i] <= r_tape[i + 1];
            end
            r_tape[TAPE_LEN - 1] <= load_data;
        end else if (r_state == S_WRITE) begin
            r_tape[r_head] <= r_sym;
        end
    end

    // Presented symbol refreshes only after a load shift or in FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur <= BLANK;
        end else if (w_load) begin
            r_cur <= w_shift_sym;
        end else if (r_state == S_FETCH) begin
            r_cur <= r_tape[r_head];
        end
    end

    // Step operands captured at accept so control may change them afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sym   <= BLANK;
            r_right <= 1'b0;
        end else if (w_accept) begin
            r_sym   <= new_sym;
            r_right <= move_right;
        end
    end

    // Sticky status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halted   <= 1'b0;
            r_edge_err <= 1'b0;
        end else begin
            if ((r_state == S_READY) && halt_in) begin
                r_halted <= 1'b1;
            end
            if (w_edge_hit) begin
                r_edge_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tape_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tape_unit
//  Description : Scoreboard bench for tape_unit. Two instances (no wrap and
//                wrap) are driven with directed and random steps and loads;
//                a tape model predicts each step's outcome.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tape_unit;

    localparam int TL = 16;

    typedef struct {
        int sym;
        int head;
        bit err;
        int acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] load_en;
    logic [1:0] step_valid;
    logic [1:0] move_right;
    logic [1:0] halt_in;
    logic [1:0] step_ready;
    logic [1:0] halted;
    logic [1:0] edge_err;
    logic [2:0] load_data [2];
    logic [2:0] new_sym   [2];
    logic [2:0] cur_sym   [2];
    logic [3:0] head_pos  [2];

    int   m_tape [2][TL];
    int   m_head [2];
    int   m_cur  [2];
    bit   m_err  [2];
    bit   m_halt [2];
    exp_t q0 [$];
    exp_t q1 [$];

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    tape_unit #(.WRAP(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .load_en(load_en[0]), .load_data(load_data[0]),
        .step_valid(step_valid[0]), .step_ready(step_ready[0]),
        .new_sym(new_sym[0]), .move_right(move_right[0]), .halt_in(halt_in[0]),
        .cur_sym(cur_sym[0]), .head_pos(head_pos[0]),
        .halted(halted[0]), .edge_err(edge_err[0])
    );

    tape_unit #(.WRAP(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .load_en(load_en[1]), .load_data(load_data[1]),
        .step_valid(step_valid[1]), .step_ready(step_ready[1]),
        .new_sym(new_sym[1]), .move_right(move_right[1]), .halt_in(halt_in[1]),
        .cur_sym(cur_sym[1]), .head_pos(head_pos[1]),
        .halted(halted[1]), .edge_err(edge_err[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < TL; i++) m_tape[d][i] = 0;
            m_head[d] = 8;
            m_cur[d]  = 0;
            m_err[d]  = 1'b0;
            m_halt[d] = 1'b0;
        end
        q0.delete();
        q1.delete();
    endtask

    // Monitor: retires one expected step result when the DUT presents it
    task automatic mon(input int d);
        exp_t e;
        if (!rst_n) return;
        if (d == 0 && q0.size() == 0) return;
        if (d == 1 && q1.size() == 0) return;
        e = (d == 0) ? q0[0] : q1[0];
        if (cyc <= e.acc) return;
        if (step_ready[d] || edge_err[d]) begin
            if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            chk($sformatf("step%0d_cur_sym", d), int'(cur_sym[d]), e.sym);
            chk($sformatf("step%0d_head", d), int'(head_pos[d]), e.head);
            chk($sformatf("step%0d_edge_err", d), int'(edge_err[d]), int'(e.err));
            chk($sformatf("step%0d_latency", d), cyc - e.acc, e.err ? 2 : 3);
        end else if (cyc - e.acc > 10) begin
            if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            chk($sformatf("step%0d_completion", d), 0, 1);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) mon(d);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        load_en    = '0;
        step_valid = '0;
        move_right = '0;
        halt_in    = '0;
        for (int d = 0; d < 2; d++) begin
            load_data[d] = '0;
            new_sym[d]   = '0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_state(input int d);
        chk($sformatf("rst%0d_cur_sym", d), int'(cur_sym[d]), 0);
        chk($sformatf("rst%0d_head", d), int'(head_pos[d]), 8);
        chk($sformatf("rst%0d_step_ready", d), int'(step_ready[d]), 1);
        chk($sformatf("rst%0d_halted", d), int'(halted[d]), 0);
        chk($sformatf("rst%0d_edge_err", d), int'(edge_err[d]), 0);
    endtask

    // One preload cycle; model shifts the tape toward cell 0
    task automatic load_one(input int d, input int val);
        @(negedge clk);
        load_en[d]   = 1'b1;
        load_data[d] = 3'(val);
        if (!(m_err[d] || m_halt[d])) begin
            for (int i = 0; i < TL - 1; i++) m_tape[d][i] = m_tape[d][i + 1];
            m_tape[d][TL - 1] = val & 7;
            m_cur[d] = m_tape[d][m_head[d]];
        end
    endtask

    task automatic load_off(input int d);
        @(negedge clk);
        load_en[d] = 1'b0;
        chk($sformatf("load%0d_cur_sym", d), int'(cur_sym[d]), m_cur[d]);
        chk($sformatf("load%0d_head", d), int'(head_pos[d]), m_head[d]);
    endtask

    task automatic step(input int d, input int sym, input bit right);
        exp_t e;
        int   nh;
        @(negedge clk);
        if (m_err[d] || m_halt[d]) begin
            step_valid[d] = 1'b1;
            new_sym[d]    = 3'(sym);
            move_right[d] = right;
            repeat (4) begin
                @(negedge clk);
                chk($sformatf("term%0d_step_ready", d), int'(step_ready[d]), 0);
            end
            step_valid[d] = 1'b0;
            chk($sformatf("term%0d_head", d), int'(head_pos[d]), m_head[d]);
            chk($sformatf("term%0d_cur_sym", d), int'(cur_sym[d]), m_cur[d]);
            chk($sformatf("term%0d_edge_err", d), int'(edge_err[d]), int'(m_err[d]));
            return;
        end
        for (int i = 0; i < 20 && !step_ready[d]; i++) @(negedge clk);
        if (!step_ready[d]) begin
            chk($sformatf("ready%0d_wait", d), 0, 1);
            return;
        end
        step_valid[d] = 1'b1;
        new_sym[d]    = 3'(sym);
        move_right[d] = right;
        m_tape[d][m_head[d]] = sym & 7;
        nh    = m_head[d] + (right ? 1 : -1);
        e.err = 1'b0;
        if (nh < 0 || nh >= TL) begin
            if (d == 1) nh = (nh + TL) % TL;
            else begin
                nh    = m_head[d];
                e.err = 1'b1;
            end
        end
        m_head[d] = nh;
        if (!e.err) m_cur[d] = m_tape[d][nh];
        m_err[d] = e.err;
        e.sym  = m_cur[d];
        e.head = nh;
        e.acc  = cyc + 1;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        @(negedge clk);
        step_valid[d] = 1'b0;
        for (int i = 0; i < 20 && ((d == 0) ? q0.size() : q1.size()) > 0; i++) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        @(negedge clk);
        chk_reset_state(0);
        chk_reset_state(1);

        // Preload ramp then step right, then step back to reveal cell 8
        for (int i = 0; i < 16; i++) load_one(0, i);
        load_off(0);
        step(0, 3'b101, 1'b1);
        step(0, 3'b011, 1'b0);

        // Walk to the left edge and off it
        do_reset();
        for (int i = 0; i < 8; i++) step(0, 3'b111, 1'b0);
        step(0, 3'b111, 1'b0);
        step(0, 3'b001, 1'b1);

        // Wrap from cell 15 to cell 0, then back to reveal cell 15
        for (int i = 0; i < 7; i++) step(1, int'($urandom_range(0, 7)), 1'b1);
        step(1, 3'b010, 1'b1);
        step(1, 3'b100, 1'b0);

        // Halt beats a simultaneous step; halted unit ignores loads and steps
        do_reset();
        @(negedge clk);
        halt_in[0]    = 1'b1;
        step_valid[0] = 1'b1;
        new_sym[0]    = 3'b111;
        move_right[0] = 1'b1;
        #1 chk("halt_step_ready", int'(step_ready[0]), 0);
        @(negedge clk);
        chk("halt_halted", int'(halted[0]), 1);
        chk("halt_head", int'(head_pos[0]), 8);
        halt_in[0]    = 1'b0;
        step_valid[0] = 1'b0;
        m_halt[0]     = 1'b1;
        @(negedge clk);
        chk("halt_ready_after", int'(step_ready[0]), 0);
        for (int i = 0; i < 4; i++) load_one(0, 5);
        load_off(0);
        step(0, 3'b011, 1'b0);

        // Reset while the step is in MOVE
        do_reset();
        @(negedge clk);
        step_valid[0] = 1'b1;
        new_sym[0]    = 3'b110;
        move_right[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        step_valid[0] = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_state(0);
        step(0, 3'b000, 1'b1);
        step(0, 3'b000, 1'b0);

        // Random mix of loads and steps on both instances
        do_reset();
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++)
                    load_one(1, int'($urandom_range(0, 7)));
                load_off(1);
            end else begin
                step(1, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            end
        end
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                load_one(0, int'($urandom_range(0, 7)));
                load_off(0);
            end else begin
                step(0, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            end
        end

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
